// File: rtl/id_operand_stage.sv
// id_operand_stage
//   ID-stage front end. It holds the IF->ID pipeline register and keeps the
//   instruction while the stage is stalled. It resolves the rs/rt operands
//   through NUM_FWD bypass sources, where index 0 is the youngest and has the
//   highest priority. It raises a load-use interlock and counts stalled cycles.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               kill the instruction held in ID
//   stall_id            downstream holds ID
//   if_valid, if_pc     fetch handshake and pc
//   inst_sram_rdata     instruction word, one cycle after its pc is captured
//   rs_used, rt_used    decoder operand-use flags
//   rf_rdata1/2         regfile read data for rs/rt
//   fwd_we/is_load/waddr/wdata   bypass sources, packed by index
//   id_valid            instruction issues to EX this cycle
//   id_pc, id_inst      pc and instruction in ID
//   rs_addr, rt_addr    register addresses to regfile
//   src1_data/src2_data resolved operands
//   stallreq            load-use interlock request
//   stall_cycles        saturating count of cycles with stallreq high
module id_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int NUM_FWD = 3,
    parameter int PC_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall_id,
    input  logic                       if_valid,
    input  logic [PC_W-1:0]            if_pc,
    input  logic [31:0]                inst_sram_rdata,
    input  logic                       rs_used,
    input  logic                       rt_used,
    input  logic [DATA_W-1:0]          rf_rdata1,
    input  logic [DATA_W-1:0]          rf_rdata2,
    input  logic [NUM_FWD-1:0]         fwd_we,
    input  logic [NUM_FWD-1:0]         fwd_is_load,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata,
    output logic                       id_valid,
    output logic [PC_W-1:0]            id_pc,
    output logic [31:0]                id_inst,
    output logic [RADDR_W-1:0]         rs_addr,
    output logic [RADDR_W-1:0]         rt_addr,
    output logic [DATA_W-1:0]          src1_data,
    output logic [DATA_W-1:0]          src2_data,
    output logic                       stallreq,
    output logic [31:0]                stall_cycles
);

    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic              r_hold_flag;
    logic [31:0]       r_hold_inst;
    logic [31:0]       r_stall_cycles;

    logic [31:0]       w_inst;
    logic [RADDR_W-1:0] w_rs_addr;
    logic [RADDR_W-1:0] w_rt_addr;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic              w_rs_load;
    logic              w_rt_load;
    logic              w_stallreq;

    // The SRAM word is only valid for one cycle. Once the stage stalls, the
    // captured copy takes over until the next load.
    assign w_inst    = ~r_valid ? 32'd0 : (r_hold_flag ? r_hold_inst : inst_sram_rdata);
    assign w_rs_addr = RADDR_W'(w_inst[25:21]);
    assign w_rt_addr = RADDR_W'(w_inst[20:16]);

    // Scan from the oldest source to the youngest so that the lowest matching
    // index overwrites the others. The load flag follows the winning source
    // only, so a younger non-load write shadows an older pending load.
    always_comb begin
        w_rs_data = rf_rdata1;
        w_rt_data = rf_rdata2;
        w_rs_load = 1'b0;
        w_rt_load = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[i*RADDR_W +: RADDR_W] == w_rs_addr)) begin
                w_rs_data = fwd_wdata[i*DATA_W +: DATA_W];
                w_rs_load = fwd_is_load[i];
            end
            if (fwd_we[i] && (fwd_waddr[i*RADDR_W +: RADDR_W] == w_rt_addr)) begin
                w_rt_data = fwd_wdata[i*DATA_W +: DATA_W];
                w_rt_load = fwd_is_load[i];
            end
        end
        // $0 reads as zero and can never be bypassed or interlocked.
        if (w_rs_addr == '0) begin
            w_rs_data = '0;
            w_rs_load = 1'b0;
        end
        if (w_rt_addr == '0) begin
            w_rt_data = '0;
            w_rt_load = 1'b0;
        end
    end

    assign w_stallreq = r_valid & ((rs_used & w_rs_load) | (rt_used & w_rt_load));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid        <= 1'b0;
            r_pc           <= '0;
            r_hold_flag    <= 1'b0;
            r_hold_inst    <= 32'd0;
            r_stall_cycles <= 32'd0;
        end else begin
            if (w_stallreq && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (flush) begin
                r_valid     <= 1'b0;
                r_hold_flag <= 1'b0;
            end else if (stall_id || w_stallreq) begin
                if (r_valid && !r_hold_flag) begin
                    r_hold_inst <= inst_sram_rdata;
                    r_hold_flag <= 1'b1;
                end
            end else begin
                r_valid     <= if_valid;
                r_pc        <= if_pc;
                r_hold_flag <= 1'b0;
            end
        end
    end

    assign id_valid     = r_valid & ~w_stallreq & ~stall_id & ~flush;
    assign id_pc        = r_pc;
    assign id_inst      = w_inst;
    assign rs_addr      = w_rs_addr;
    assign rt_addr      = w_rt_addr;
    assign src1_data    = w_rs_data;
    assign src2_data    = w_rt_data;
    assign stallreq     = w_stallreq;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage
//   Directed bench for id_operand_stage. The stimulus drives each cycle just
//   after the rising edge and queues the responses it expects for that cycle.
//   The monitor pops and compares those responses on the falling edge.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst, flush, stall_id, if_valid;
    logic [31:0] if_pc, inst_sram_rdata;
    logic        rs_used, rt_used;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [2:0]  fwd_we, fwd_is_load;
    logic [14:0] fwd_waddr;
    logic [95:0] fwd_wdata;
    logic        id_valid, stallreq;
    logic [31:0] id_pc, id_inst, src1_data, src2_data, stall_cycles;
    logic [4:0]  rs_addr, rt_addr;

    id_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id),
        .if_valid(if_valid), .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
        .rs_used(rs_used), .rt_used(rt_used),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_is_load(fwd_is_load),
        .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .src1_data(src1_data), .src2_data(src2_data),
        .stallreq(stallreq), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mask bits: 0 id_valid, 1 id_pc, 2 id_inst, 3 src1, 4 src2, 5 stallreq, 6 stall_cycles
    typedef struct {
        string       name;
        int          cyc;
        logic [6:0]  m;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        sr;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, want %h", name, field, act, exp);
        end
    endtask

    function automatic exp_t blank(input string name);
        exp_t e;
        e.name = name; e.cyc = cyc; e.m = '0;
        e.v = 1'b0; e.pc = '0; e.inst = '0; e.s1 = '0; e.s2 = '0; e.sr = 1'b0; e.cnt = '0;
        return e;
    endfunction

    task automatic exp_core(input string name, input logic v, input logic [31:0] pc,
                            input logic [31:0] inst, input logic sr);
        exp_t e = blank(name);
        e.m = 7'b010_0111; e.v = v; e.pc = pc; e.inst = inst; e.sr = sr;
        q.push_back(e);
    endtask

    task automatic exp_src(input string name, input logic [31:0] s1, input logic [31:0] s2);
        exp_t e = blank(name);
        e.m = 7'b001_1000; e.s1 = s1; e.s2 = s2;
        q.push_back(e);
    endtask

    task automatic exp_cnt(input string name, input logic [31:0] cnt);
        exp_t e = blank(name);
        e.m = 7'b100_0000; e.cnt = cnt;
        q.push_back(e);
    endtask

    // Monitor: compare everything queued for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_tests++; n_fail++;
                $display("FAIL %s.stale: got cycle %0d, want cycle %0d", e.name, cyc, e.cyc);
            end else begin
                if (e.m[0]) chk(e.name, "id_valid", {31'd0, id_valid}, {31'd0, e.v});
                if (e.m[1]) chk(e.name, "id_pc", id_pc, e.pc);
                if (e.m[2]) chk(e.name, "id_inst", id_inst, e.inst);
                if (e.m[3]) chk(e.name, "src1", src1_data, e.s1);
                if (e.m[4]) chk(e.name, "src2", src2_data, e.s2);
                if (e.m[5]) chk(e.name, "stallreq", {31'd0, stallreq}, {31'd0, e.sr});
                if (e.m[6]) chk(e.name, "stall_cycles", stall_cycles, e.cnt);
            end
        end
    end

    function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h0, rs, rt, 16'h1234};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_fwd();
        fwd_we = '0; fwd_is_load = '0; fwd_waddr = '0; fwd_wdata = '0;
    endtask

    task automatic set_fwd(input int i, input logic ld, input logic [4:0] a, input logic [31:0] d);
        fwd_we[i]           = 1'b1;
        fwd_is_load[i]      = ld;
        fwd_waddr[i*5 +: 5] = a;
        fwd_wdata[i*32 +: 32] = d;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; stall_id = 1'b0; if_valid = 1'b0; if_pc = '0;
        inst_sram_rdata = '0; rs_used = 1'b0; rt_used = 1'b0;
        rf_rdata1 = 32'h1111; rf_rdata2 = 32'h2222;
        clr_fwd();

        // reset, two cycles
        step();
        exp_core("rst1", 0, 0, 0, 0); exp_src("rst1", 0, 0); exp_cnt("rst1", 0);
        step();
        if_valid = 1'b1; if_pc = 32'h100;
        exp_core("rst2", 0, 0, 0, 0); exp_src("rst2", 0, 0); exp_cnt("rst2", 0);
        step();
        rst = 1'b0;
        exp_core("post_rst", 0, 0, 0, 0);

        // bypass priority: EX and MEM both write r5
        step();
        inst_sram_rdata = mk_inst(5, 6); rs_used = 1; rt_used = 1;
        clr_fwd(); set_fwd(0, 0, 5, 32'hAA); set_fwd(1, 0, 5, 32'hBB);
        if_pc = 32'h104;
        exp_core("fwd_pri", 1, 32'h100, mk_inst(5, 6), 0); exp_src("fwd_pri", 32'hAA, 32'h2222);

        // WB-only match for rs, MEM match for rt
        step();
        inst_sram_rdata = mk_inst(5, 7);
        clr_fwd(); set_fwd(1, 0, 7, 32'hBB); set_fwd(2, 0, 5, 32'hCC);
        if_pc = 32'h108;
        exp_core("fwd_wb", 1, 32'h104, mk_inst(5, 7), 0); exp_src("fwd_wb", 32'hCC, 32'hBB);

        // load-use on rt from EX
        step();
        inst_sram_rdata = mk_inst(3, 8);
        clr_fwd(); set_fwd(0, 1, 8, 32'hDEAD);
        if_pc = 32'h10C;
        exp_core("ldu", 0, 32'h108, mk_inst(3, 8), 1); exp_src("ldu", 32'h1111, 32'hDEAD); exp_cnt("ldu", 0);
        step();
        inst_sram_rdata = 32'hFFFF_0000; rf_rdata2 = 32'h8888;
        clr_fwd();
        exp_core("ldu_rel", 1, 32'h108, mk_inst(3, 8), 0); exp_src("ldu_rel", 32'h1111, 32'h8888); exp_cnt("ldu_rel", 1);

        // unused rt does not interlock; r0 is never bypassed
        step();
        inst_sram_rdata = mk_inst(0, 8); rs_used = 1; rt_used = 0;
        clr_fwd(); set_fwd(0, 1, 8, 32'h77); set_fwd(1, 1, 0, 32'hFFFF_FFFF);
        if_pc = 32'h110;
        exp_core("rt_unused", 1, 32'h10C, mk_inst(0, 8), 0); exp_src("r0", 0, 32'h77);

        // older load shadowed by younger non-load
        step();
        inst_sram_rdata = mk_inst(4, 0);
        clr_fwd(); set_fwd(0, 0, 4, 32'h44); set_fwd(1, 1, 4, 32'h55);
        if_pc = 32'h114;
        exp_core("shadow", 1, 32'h110, mk_inst(4, 0), 0); exp_src("shadow", 32'h44, 0);

        // stall_id for three cycles while SRAM data keeps changing
        step();
        clr_fwd(); stall_id = 1; inst_sram_rdata = 32'hA000_0001; if_pc = 32'h118;
        exp_core("hold1", 0, 32'h114, 32'hA000_0001, 0);
        step();
        inst_sram_rdata = 32'hA000_0002;
        exp_core("hold2", 0, 32'h114, 32'hA000_0001, 0);
        step();
        inst_sram_rdata = 32'hA000_0003;
        exp_core("hold3", 0, 32'h114, 32'hA000_0001, 0);
        step();
        stall_id = 0; inst_sram_rdata = 32'hA000_0004;
        exp_core("hold_rel", 1, 32'h114, 32'hA000_0001, 0);
        step();
        inst_sram_rdata = 32'hB000_0000; if_pc = 32'h11C;
        exp_core("next_pc", 1, 32'h118, 32'hB000_0000, 0);

        // flush while interlocked
        step();
        inst_sram_rdata = mk_inst(9, 0); rs_used = 1; rt_used = 0;
        clr_fwd(); set_fwd(0, 1, 9, 32'h99); flush = 1;
        exp_core("flush_ldu", 0, 32'h11C, mk_inst(9, 0), 1); exp_cnt("flush_ldu", 1);
        step();
        flush = 0; if_pc = 32'h120;
        exp_core("flushed", 0, 32'h11C, 0, 0); exp_cnt("flushed", 2);

        // counter saturation with a MEM-stage load
        step();
        clr_fwd(); set_fwd(1, 1, 9, 32'h99);
        force dut.r_stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cycles;
        exp_core("sat_ldu", 0, 32'h120, mk_inst(9, 0), 1);
        step();
        inst_sram_rdata = 32'h1234_5678;
        exp_core("sat1", 0, 32'h120, mk_inst(9, 0), 1); exp_cnt("sat1", 32'hFFFF_FFFF);
        step();
        exp_cnt("sat2", 32'hFFFF_FFFF);
        clr_fwd(); if_pc = 32'h124;
        exp_core("sat_rel", 1, 32'h120, mk_inst(9, 0), 0);

        // reset while holding discards the hold
        step();
        stall_id = 1; inst_sram_rdata = 32'hC000_0001;
        exp_core("rh_stall", 0, 32'h124, 32'hC000_0001, 0);
        step();
        rst = 1; inst_sram_rdata = 32'hC000_0002;
        exp_core("rh_held", 0, 32'h124, 32'hC000_0001, 0);
        step();
        rst = 0; stall_id = 0; if_pc = 32'h200;
        exp_core("rh_reset", 0, 0, 0, 0); exp_cnt("rh_reset", 0);
        step();
        inst_sram_rdata = 32'hC000_0003;
        exp_core("rh_fresh", 1, 32'h200, 32'hC000_0003, 0);

        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL %s.unchecked: got none, want check at cycle %0d", e.name, e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
